mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Two-port round-robin arbiter and sequencer for the 32x8 synchronous memory (mem modport: addr_rn, data_in, read, write in; data_out out).
- Two independent requesters, e.g. a test stimulus driver and a checker/scrubber, share one memory.
- The block serialises their accesses and generates the read/write strobe timing on the memory side.
- It returns read data to the requester that issued the read.

Parameters:
ADDR_W, 5, memory address width
DATA_W, 8, memory data width

Ports:
clk  input  1  clock, all state updates on rising edge
rst_  input  1  synchronous active-low reset, sampled on rising edge of clk
req0  input  1  port 0 request; held high until gnt0 seen
we0  input  1  port 0: 1=write, 0=read
addr0  input  ADDR_W  port 0 address
wdata0  input  DATA_W  port 0 write data
gnt0  output  1  port 0 grant, one-cycle pulse
done0  output  1  port 0 completion pulse (write done or read data valid)
rdata0  output  DATA_W  port 0 read data, valid when done0=1
req1, we1, addr1, wdata1, gnt1, done1, rdata1  as port 0, for port 1
mem_addr  output  ADDR_W  to memory addr_rn
mem_data_in  output  DATA_W  to memory data_in
mem_read  output  1  to memory read
mem_write  output  1  to memory write
mem_data_out  input  DATA_W  from memory data_out; updated by memory on the edge that samples mem_read=1

Behaviour:
- Reset (rst_=0 at a rising edge):
  - state=IDLE; last_gnt=1, so port 0 wins the first contention.
  - All outputs 0: gnt*, done*, rdata*, mem_*.
  - Any in-flight transaction is dropped with no done pulse. Reset wins over every other event.
- States: IDLE, ACCESS, RDCAP. All outputs are registered.
- IDLE, at edge E0:
  - If no req: stay in IDLE; mem_read and mem_write stay 0.
  - If exactly one req: grant that port.
  - If both req: grant the port != last_gnt, then update last_gnt.
  - On grant, at E0: gnt<p><=1 for one cycle; latch we/addr/wdata of port p; mem_addr<=addr; mem_data_in<=wdata (writes only; otherwise hold); mem_write<=we; mem_read<=~we; state->ACCESS.
- ACCESS, at edge E1:
  - The memory samples the strobe at E1.
  - mem_read<=0 and mem_write<=0.
  - Write: done<p><=1 for one cycle; state->IDLE.
  - Read: state->RDCAP.
- RDCAP, at edge E2: rdata<p><=mem_data_out; done<p><=1 for one cycle; state->IDLE.
- Latency, counted from the edge that samples req:
  - Write: gnt after E0, done after E1, next grant possible at E2. Throughput is one write per 2 cycles.
  - Read: gnt after E0, done+rdata after E2, next grant possible at E3. Throughput is one read per 3 cycles.
- Request rules:
  - Command fields are sampled only at the granting edge. The requester may change them after gnt.
  - req still high when the arbiter next returns to IDLE counts as a new request. A requester wanting one access drops req in the cycle gnt is high.
  - req is ignored in ACCESS and RDCAP; requests are never lost, only delayed.
- Output holds:
  - rdata<p> holds its last value until the next read completes for port p.
  - mem_addr and mem_data_in hold between accesses.
- Mutual exclusion: gnt0 & gnt1 == 0, mem_read & mem_write == 0, and at most one done per cycle.
- Address range: addr 0..31 passes straight through; no wrap logic.

Test Plan:
- Write then read, port 0:
  - req0, we0=1, addr0=5, wdata0=8'hA5 -> gnt0 one cycle later; mem_write=1, mem_addr=5, mem_data_in=A5 for exactly one cycle; done0 next cycle.
  - Then read addr 5 -> mem_read one cycle; done0 with rdata0=A5 two cycles after gnt0.
- Contention: req0 and req1 both high from reset, holding until granted, with reads to addr 1 (0x11) and addr 2 (0x22) -> gnt0 first, then gnt1. Check rdata0=11 and rdata1=22, done0 before done1, never both gnt.
- Fairness: both ports hold req continuously for 8 writes -> grants alternate 0,1,0,1...; each port gets 4; two cycles between grants.
- Single requester streaming: req1 held high for 4 writes to addrs 0..3 with data 0x40..0x43 -> 4 consecutive port-1 grants spaced 2 cycles apart; readback returns 0x40..0x43.
- Reset mid-read: assert rst_=0 in RDCAP -> no done0; all outputs 0 next cycle. After release, the first contention grants port 0.
- Idle: no req for 10 cycles -> mem_read, mem_write, gnt*, done* all stay 0; mem_addr holds its last value.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter/sequencer for a 32x8 synchronous memory.
// Serialises port accesses, drives the memory strobes and routes read data back.
module mem_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              done0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              done1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_data_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDCAP  = 2'd2
  } state_t;

  state_t              state_r, state_s;
  logic                last_gnt_r, last_gnt_s;
  logic                port_r, port_s;
  logic                we_r, we_s;
  logic                gnt0_s, gnt1_s, done0_s, done1_s;
  logic [DATA_W-1:0]   rdata0_s, rdata1_s;
  logic [ADDR_W-1:0]   mem_addr_s;
  logic [DATA_W-1:0]   mem_data_in_s;
  logic                mem_read_s, mem_write_s;
  logic                pick1_s, sel_we_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [DATA_W-1:0]   sel_wdata_s;

  // Next-state, grant selection and next values of every registered output
  always_comb begin
    state_s       = state_r;
    last_gnt_s    = last_gnt_r;
    port_s        = port_r;
    we_s          = we_r;
    gnt0_s        = 1'b0;
    gnt1_s        = 1'b0;
    done0_s       = 1'b0;
    done1_s       = 1'b0;
    rdata0_s      = rdata0;
    rdata1_s      = rdata1;
    mem_addr_s    = mem_addr;
    mem_data_in_s = mem_data_in;
    mem_read_s    = mem_read;
    mem_write_s   = mem_write;
    // Port 1 wins when it is the only requester, or on contention when port 0 went last.
    pick1_s       = req1 & (~req0 | ~last_gnt_r);
    sel_we_s      = pick1_s ? we1 : we0;
    sel_addr_s    = pick1_s ? addr1 : addr0;
    sel_wdata_s   = pick1_s ? wdata1 : wdata0;

    case (state_r)
      IDLE: begin
        if (req0 | req1) begin
          port_s        = pick1_s;
          last_gnt_s    = pick1_s;
          we_s          = sel_we_s;
          gnt0_s        = ~pick1_s;
          gnt1_s        = pick1_s;
          mem_addr_s    = sel_addr_s;
          mem_data_in_s = sel_we_s ? sel_wdata_s : mem_data_in;
          mem_write_s   = sel_we_s;
          mem_read_s    = ~sel_we_s;
          state_s       = ACCESS;
        end else begin
          mem_read_s    = 1'b0;
          mem_write_s   = 1'b0;
        end
      end
      ACCESS: begin
        mem_read_s  = 1'b0;
        mem_write_s = 1'b0;
        if (we_r) begin
          done0_s = ~port_r;
          done1_s = port_r;
          state_s = IDLE;
        end else begin
          state_s = RDCAP;
        end
      end
      RDCAP: begin
        // Memory updated data_out on the edge that sampled the read strobe.
        if (port_r) begin
          rdata1_s = mem_data_out;
          done1_s  = 1'b1;
        end else begin
          rdata0_s = mem_data_out;
          done0_s  = 1'b1;
        end
        state_s = IDLE;
      end
      default: begin
        mem_read_s  = 1'b0;
        mem_write_s = 1'b0;
        state_s     = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_r     <= IDLE;
      last_gnt_r  <= 1'b1;
      port_r      <= 1'b0;
      we_r        <= 1'b0;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      done0       <= 1'b0;
      done1       <= 1'b0;
      rdata0      <= {DATA_W{1'b0}};
      rdata1      <= {DATA_W{1'b0}};
      mem_addr    <= {ADDR_W{1'b0}};
      mem_data_in <= {DATA_W{1'b0}};
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
    end else begin
      state_r     <= state_s;
      last_gnt_r  <= last_gnt_s;
      port_r      <= port_s;
      we_r        <= we_s;
      gnt0        <= gnt0_s;
      gnt1        <= gnt1_s;
      done0       <= done0_s;
      done1       <= done1_s;
      rdata0      <= rdata0_s;
      rdata1      <= rdata1_s;
      mem_addr    <= mem_addr_s;
      mem_data_in <= mem_data_in_s;
      mem_read    <= mem_read_s;
      mem_write   <= mem_write_s;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural 32x8 memory.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst_;
  logic       req0, we0, req1, we1;
  logic [4:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, done0, gnt1, done1;
  logic [7:0] rdata0, rdata1;
  logic [4:0] mem_addr;
  logic [7:0] mem_data_in;
  logic       mem_read, mem_write;
  logic [7:0] mem_data_out = 8'h00;
  logic [7:0] mem_model [0:31];

  int n_cmp = 0;
  int n_err = 0;

  mem_arbiter #(.ADDR_W(5), .DATA_W(8)) dut (
    .clk(clk), .rst_(rst_),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .done0(done0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .done1(done1), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  // Synchronous memory: write and read strobes sampled on the rising edge
  always @(posedge clk) begin
    if (mem_write) mem_model[mem_addr] <= mem_data_in;
    if (mem_read) mem_data_out <= mem_model[mem_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Mutual exclusion on every cycle outside reset
  always @(negedge clk) begin
    if (rst_ === 1'b1)
      chk("mutex", {61'd0, gnt0 & gnt1, mem_read & mem_write, done0 & done1}, 64'd0);
  end

  task automatic drive(input int p, input logic r, input logic w, input logic [4:0] a, input logic [7:0] d);
    if (p == 0) begin
      req0 = r; we0 = w; addr0 = a; wdata0 = d;
    end else begin
      req1 = r; we1 = w; addr1 = a; wdata1 = d;
    end
  endtask

  // Wait for this port's grant with a cycle budget; returns 1 if granted
  task automatic wait_gnt(input int p, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if ((p == 0 && gnt0) || (p == 1 && gnt1)) begin
        ok = 1'b1;
        break;
      end
    end
    chk("gnt_seen", {63'd0, ok}, 64'd1);
  endtask

  task automatic wr(input int p, input logic [4:0] a, input logic [7:0] d);
    logic ok;
    drive(p, 1'b1, 1'b1, a, d);
    wait_gnt(p, ok);
    drive(p, 1'b0, 1'b0, 5'd0, 8'd0);
    chk("wr_strobe", {49'd0, mem_write, mem_read, mem_addr, mem_data_in}, {49'd0, 1'b1, 1'b0, a, d});
    cyc();
    chk("wr_done", {61'd0, (p == 0) ? done0 : done1, (p == 0) ? done1 : done0, mem_write},
        {61'd0, 1'b1, 1'b0, 1'b0});
    cyc();
  endtask

  task automatic rd(input int p, input logic [4:0] a, input logic [7:0] exp);
    logic ok;
    drive(p, 1'b1, 1'b0, a, 8'd0);
    wait_gnt(p, ok);
    drive(p, 1'b0, 1'b0, 5'd0, 8'd0);
    chk("rd_strobe", {57'd0, mem_write, mem_read, mem_addr}, {57'd0, 1'b0, 1'b1, a});
    cyc();
    chk("rd_wait", {61'd0, done0, done1, mem_read}, 64'd0);
    cyc();
    chk("rd_done", {55'd0, (p == 0) ? done0 : done1, (p == 0) ? rdata0 : rdata1}, {55'd0, 1'b1, exp});
    cyc();
    chk("rd_hold", {55'd0, (p == 0) ? done0 : done1, (p == 0) ? rdata0 : rdata1}, {55'd0, 1'b0, exp});
  endtask

  function automatic logic [63:0] all_outs();
    return {29'd0, gnt0, gnt1, done0, done1, rdata0, rdata1, mem_addr, mem_data_in, mem_read, mem_write};
  endfunction

  initial begin
    int n0, n1;
    rst_ = 1'b0;
    drive(0, 1'b0, 1'b0, 5'd0, 8'd0);
    drive(1, 1'b0, 1'b0, 5'd0, 8'd0);
    cyc(); cyc(); cyc();
    chk("reset_outs", all_outs(), 64'd0);
    rst_ = 1'b1;

    // Write then read on port 0
    wr(0, 5'd5, 8'hA5);
    rd(0, 5'd5, 8'hA5);

    // Preload for contention, then contention straight out of reset
    wr(0, 5'd1, 8'h11);
    wr(1, 5'd2, 8'h22);
    rst_ = 1'b0;
    cyc(); cyc();
    drive(0, 1'b1, 1'b0, 5'd1, 8'd0);
    drive(1, 1'b1, 1'b0, 5'd2, 8'd0);
    rst_ = 1'b1;
    cyc();
    chk("cont_gnt0", {62'd0, gnt1, gnt0}, 64'd1);
    drive(0, 1'b0, 1'b0, 5'd0, 8'd0);
    cyc(); cyc();
    chk("cont_done0", {55'd0, done1, done0, rdata0}, {55'd0, 1'b0, 1'b1, 8'h11});
    cyc();
    chk("cont_gnt1", {62'd0, gnt1, gnt0}, 64'd2);
    drive(1, 1'b0, 1'b0, 5'd0, 8'd0);
    cyc(); cyc();
    chk("cont_done1", {55'd0, done1, done0, rdata1}, {55'd0, 1'b1, 1'b0, 8'h22});
    cyc();

    // Fairness: both hold write requests for 8 grants
    drive(0, 1'b1, 1'b1, 5'd8, 8'h80);
    drive(1, 1'b1, 1'b1, 5'd16, 8'h90);
    n0 = 0; n1 = 0;
    for (int c = 1; c <= 16; c++) begin
      cyc();
      n0 += int'(gnt0);
      n1 += int'(gnt1);
      if (c % 2 == 1) chk("fair_gnt", {62'd0, gnt1, gnt0}, ((c / 2) % 2 == 0) ? 64'd1 : 64'd2);
      else chk("fair_gap", {62'd0, gnt1, gnt0}, 64'd0);
      if (c == 15) begin
        drive(0, 1'b0, 1'b0, 5'd0, 8'd0);
        drive(1, 1'b0, 1'b0, 5'd0, 8'd0);
      end
    end
    chk("fair_cnt", {n0[31:0], n1[31:0]}, {32'd4, 32'd4});

    // Port 1 streaming writes to 0..3, fields updated after each grant
    drive(1, 1'b1, 1'b1, 5'd0, 8'h40);
    for (int c = 1; c <= 8; c++) begin
      cyc();
      chk("strm_gnt", {63'd0, gnt1}, (c % 2 == 1) ? 64'd1 : 64'd0);
      if (c % 2 == 1) begin
        chk("strm_mem", {51'd0, mem_addr, mem_data_in}, {51'd0, 5'((c - 1) / 2), 8'(8'h40 + (c - 1) / 2)});
        if (c == 7) drive(1, 1'b0, 1'b0, 5'd0, 8'd0);
        else drive(1, 1'b1, 1'b1, 5'((c + 1) / 2), 8'(8'h40 + (c + 1) / 2));
      end
    end
    for (int a = 0; a < 4; a++) rd(0, 5'(a), 8'(8'h40 + a));

    // Reset while the read is in RDCAP
    drive(0, 1'b1, 1'b0, 5'd3, 8'd0);
    cyc();
    chk("mid_gnt", {63'd0, gnt0}, 64'd1);
    drive(0, 1'b0, 1'b0, 5'd0, 8'd0);
    cyc();
    rst_ = 1'b0;
    cyc();
    chk("mid_reset_outs", all_outs(), 64'd0);
    rst_ = 1'b1;
    cyc();
    chk("mid_no_done", {62'd0, done0, done1}, 64'd0);
    drive(0, 1'b1, 1'b1, 5'd7, 8'h77);
    drive(1, 1'b1, 1'b1, 5'd9, 8'h99);
    cyc();
    chk("post_gnt0", {62'd0, gnt1, gnt0}, 64'd1);
    drive(0, 1'b0, 1'b0, 5'd0, 8'd0);
    cyc();
    chk("post_done0", {63'd0, done0}, 64'd1);
    cyc();
    chk("post_gnt1", {62'd0, gnt1, gnt0}, 64'd2);
    drive(1, 1'b0, 1'b0, 5'd0, 8'd0);
    cyc(); cyc();

    // Idle: strobes quiet and mem_addr holds the last address
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("idle", {53'd0, mem_read, mem_write, gnt0, gnt1, done0, done1, mem_addr}, {53'd0, 6'd0, 5'd9});
    end
    rd(1, 5'd7, 8'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
